// File: rtl/key_pkg.sv
// Shared constants for the multi-key debouncer.
// Key polarity plus default cycle counts for a 50 MHz clock.
package key_pkg;

   localparam logic KEY_PRESSED  = 1'b0;
   localparam logic KEY_RELEASED = 1'b1;

   // 20 ms and 1 s at 50 MHz
   localparam int DB_20MS = 1_000_000;
   localparam int LONG_1S = 50_000_000;

endpackage

// File: rtl/key_debounce_ch.sv
// One debounce channel: 2-flop sync, stability counter, edge strobes,
// optional hold detector (KEY_LONG_PRESS_EN).
// Ports: sys_clk, sys_rst_n (async, active low), key (raw, 0 = pressed),
//        key_value, key_flag, key_press, key_release, key_long.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DB_20MS,
   parameter int LONG_CYCLES     = LONG_1S
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic key,
   output logic key_value,
   output logic key_flag,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          value_q, value_d;
   logic          press_q, press_d;
   logic          release_q, release_d;
   logic          key_s;

   assign key_s = sync_q[1];

   always_comb begin
      sync_d = {sync_q[0], key};
   end

   // Any sample equal to the accepted level restarts the run.
   always_comb begin
      cnt_d     = '0;
      value_d   = value_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (key_s != value_q) begin
         if (cnt_q == CNT_MAX) begin
            value_d   = key_s;
            press_d   = (key_s == KEY_PRESSED);
            release_d = (key_s == KEY_RELEASED);
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync_q    <= {2{KEY_RELEASED}};
         cnt_q     <= '0;
         value_q   <= KEY_RELEASED;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         cnt_q     <= cnt_d;
         value_q   <= value_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   assign key_value   = value_q;
   assign key_press   = press_q;
   assign key_release = release_q;
   assign key_flag    = press_q | release_q;

`ifdef KEY_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_CYCLES);
   localparam logic [LW-1:0] LCNT_MAX = LW'(LONG_CYCLES - 1);

   logic [LW-1:0] lcnt_q, lcnt_d;
   logic          done_q, done_d;
   logic          long_q, long_d;

   // lcnt saturates at its max; done_q blocks a repeat pulse
   // until the key is released.
   always_comb begin
      lcnt_d = lcnt_q;
      done_d = done_q;
      long_d = 1'b0;
      if (value_q == KEY_RELEASED) begin
         lcnt_d = '0;
         done_d = 1'b0;
      end else if (lcnt_q == LCNT_MAX) begin
         if (!done_q) begin
            long_d = 1'b1;
            done_d = 1'b1;
         end
      end else begin
         lcnt_d = lcnt_q + LW'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lcnt_q <= '0;
         done_q <= 1'b0;
         long_q <= 1'b0;
      end else begin
         lcnt_q <= lcnt_d;
         done_q <= done_d;
         long_q <= long_d;
      end
   end

   assign key_long = long_q;
`else
   // Hold detection compiled out; output is a constant zero.
   localparam logic LONG_CFG_OK = (LONG_CYCLES > DEBOUNCE_CYCLES);
   assign key_long = LONG_CFG_OK & 1'b0;
`endif

endmodule

// File: rtl/key_debounce_multi.sv
// Debouncer for NUM_KEYS independent active-low keys.
// Ports: sys_clk, sys_rst_n (async, active low), key[N] raw pins,
//        key_value[N] debounced level, key_flag/press/release/long[N] strobes.
// Optional hold detection: define KEY_LONG_PRESS_EN.
module key_debounce_multi
   import key_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = DB_20MS,
   parameter int LONG_CYCLES     = LONG_1S
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [NUM_KEYS-1:0] key,
   output logic [NUM_KEYS-1:0] key_value,
   output logic [NUM_KEYS-1:0] key_flag,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES)
      ) u_ch (
         .sys_clk     (sys_clk),
         .sys_rst_n   (sys_rst_n),
         .key         (key[i]),
         .key_value   (key_value[i]),
         .key_flag    (key_flag[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .key_long    (key_long[i])
      );
   end

endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: directed scenarios plus random bouncing,
// checked every cycle against a sample-window reference model.
module tb_key_debounce_multi;

   localparam int NK = 4;
   localparam int DB = 8;
   localparam int LC = 32;
   localparam int HL = DB + 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NK-1:0] key = '1;
   logic [NK-1:0] kv, kf, kp, kr, kl;

   int n_chk = 0;
   int n_pass = 0;

   // reference model state
   logic          hist [NK][HL];
   int unsigned   hold [NK];
   logic [NK-1:0] m_val, m_p, m_r, m_l;

   key_debounce_multi #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (DB),
      .LONG_CYCLES     (LC)
   ) dut (
      .sys_clk     (clk),
      .sys_rst_n   (rst_n),
      .key         (key),
      .key_value   (kv),
      .key_flag    (kf),
      .key_press   (kp),
      .key_release (kr),
      .key_long    (kl)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h t=%0t",
                    tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_val = '1;
      m_p = '0;
      m_r = '0;
      m_l = '0;
      for (int k = 0; k < NK; k++) begin
         hold[k] = 0;
         for (int i = 0; i < HL; i++) hist[k][i] = 1'b1;
      end
   endtask

   // A level is accepted when the DB samples that have cleared the
   // two-stage synchroniser all disagree with the current level.
   task automatic model_step(input logic [NK-1:0] raw);
      bit all_diff;
      m_p = '0;
      m_r = '0;
      m_l = '0;
      for (int k = 0; k < NK; k++) begin
         for (int i = 0; i < HL - 1; i++) hist[k][i] = hist[k][i+1];
         hist[k][HL-1] = raw[k];
         if (m_val[k] == 1'b0) begin
            hold[k]++;
`ifdef KEY_LONG_PRESS_EN
            if (hold[k] == LC) m_l[k] = 1'b1;
`endif
         end
         all_diff = 1'b1;
         for (int i = 0; i < DB; i++)
            if (hist[k][i] == m_val[k]) all_diff = 1'b0;
         if (all_diff) begin
            m_val[k] = ~m_val[k];
            hold[k]  = 0;
            if (m_val[k] == 1'b0) m_p[k] = 1'b1;
            else m_r[k] = 1'b1;
         end
      end
   endtask

   task automatic cyc(input logic [NK-1:0] k, input logic r);
      @(negedge clk);
      key   = k;
      rst_n = r;
      @(posedge clk);
      #1;
      if (!r) model_reset();
      else model_step(k);
      check("key_value", kv, m_val);
      check("key_press", kp, m_p);
      check("key_release", kr, m_r);
      check("key_flag", kf, m_p | m_r);
      check("key_long", kl, m_l);
   endtask

   initial begin
      logic [NK-1:0] k;
      int first;
      int nlong;
      int p;
      model_reset();

      // 1: reset then idle
      repeat (3) cyc(4'hF, 1'b0);
      for (int i = 0; i < 100; i++) cyc(4'hF, 1'b1);

      // 2: clean press/release of key 0
      first = -1;
      for (int i = 0; i < 20; i++) begin
         cyc(4'hE, 1'b1);
         if (kp[0] && first < 0) first = i;
      end
      check("press_edge0", first, 9);
      first = -1;
      for (int i = 0; i < 20; i++) begin
         cyc(4'hF, 1'b1);
         if (kr[0] && first < 0) first = i;
      end
      check("release_edge0", first, 9);

      // 3: bounces on key 1, then steady low
      for (int b = 0; b < 6; b++) begin
         repeat (5) cyc(4'hD, 1'b1);
         repeat (3) cyc(4'hF, 1'b1);
      end
      check("bounce_value1", kv, 4'hF);
      first = -1;
      for (int i = 0; i < 20; i++) begin
         cyc(4'hD, 1'b1);
         if (kp[1] && first < 0) first = i;
      end
      check("press_edge1", first, 9);
      repeat (20) cyc(4'hF, 1'b1);

      // 4: keys 2 and 3 together
      first = -1;
      for (int i = 0; i < 20; i++) begin
         cyc(4'h3, 1'b1);
         if (kp != 0 && first < 0) begin
            first = i;
            check("dual_press", kp, 4'hC);
         end
      end
      check("dual_edge", first, 9);
      repeat (20) cyc(4'hF, 1'b1);

      // 5: long hold of key 0, twice
      for (int rep = 0; rep < 2; rep++) begin
         first = -1;
         nlong = 0;
         for (int i = 0; i < 80; i++) begin
            cyc(4'hE, 1'b1);
            if (kl[0]) begin
               nlong++;
               if (first < 0) first = i;
            end
         end
`ifdef KEY_LONG_PRESS_EN
         check("long_edge", first, 9 + LC);
         check("long_count", nlong, 1);
`else
         check("long_count", nlong, 0);
`endif
         repeat (20) cyc(4'hF, 1'b1);
      end

      // 6: reset mid-count with key 1 held
      repeat (7) cyc(4'hD, 1'b1);
      repeat (2) cyc(4'hD, 1'b0);
      check("rst_value", kv, 4'hF);
      first = -1;
      for (int i = 0; i < 20; i++) begin
         cyc(4'hD, 1'b1);
         if (kp[1] && first < 0) first = i;
      end
      check("rst_press_edge", first, 9);

      // random bouncing with varying toggle rates and rare resets
      k = 4'hD;
      for (int blk = 0; blk < 12; blk++) begin
         p = $urandom_range(60, 3);
         for (int i = 0; i < 200; i++) begin
            for (int j = 0; j < NK; j++)
               if ($urandom_range(p - 1, 0) == 0) k[j] = ~k[j];
            cyc(k, ($urandom_range(499, 0) != 0));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
